// File: rtl/tinyml_axi_pkg.sv
// -----------------------------------------------------------------------------
// tinyml_axi_pkg
// Shared definitions for the half-duplex AXI arbiter: arbiter state encoding,
// fixed AXI field widths and the position of the requester-select bit that is
// prefixed onto IDs on the DDR side.
// -----------------------------------------------------------------------------
package tinyml_axi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    // The requester index sits directly above the requester's own ID bits.
    function automatic int id_prefix_pos(input int id_width);
        return id_width;
    endfunction

endpackage

// File: rtl/tinyml_axi_hd_arbiter_if.sv
// -----------------------------------------------------------------------------
// tinyml_axi_hd_arbiter_if
// One half-duplex AXI bundle: combined AR/AW request (arw), write data (w),
// write response (b) and read data (r).
//   master modport : drives arw/w and the b/r readies (requester or DDR port
//                    as seen from the arbiter)
//   slave modport  : receives arw/w and drives b/r (arbiter's requester side)
// -----------------------------------------------------------------------------
interface tinyml_axi_hd_arbiter_if
    import tinyml_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic                    arw_valid;
    logic                    arw_ready;
    logic [ADDR_WIDTH-1:0]   arw_payload_addr;
    logic [ID_WIDTH-1:0]     arw_payload_id;
    logic [LEN_W-1:0]        arw_payload_len;
    logic [SIZE_W-1:0]       arw_payload_size;
    logic [BURST_W-1:0]      arw_payload_burst;
    logic                    arw_payload_lock;
    logic                    arw_payload_write;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_payload_data;
    logic [DATA_WIDTH/8-1:0] w_payload_strb;
    logic                    w_payload_last;
    logic [ID_WIDTH-1:0]     w_payload_id;

    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     b_payload_id;

    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_payload_data;
    logic [ID_WIDTH-1:0]     r_payload_id;
    logic [RESP_W-1:0]       r_payload_resp;
    logic                    r_payload_last;

    modport master (
        output arw_valid, arw_payload_addr, arw_payload_id, arw_payload_len,
               arw_payload_size, arw_payload_burst, arw_payload_lock, arw_payload_write,
        input  arw_ready,
        output w_valid, w_payload_data, w_payload_strb, w_payload_last, w_payload_id,
        input  w_ready,
        input  b_valid, b_payload_id,
        output b_ready,
        input  r_valid, r_payload_data, r_payload_id, r_payload_resp, r_payload_last,
        output r_ready
    );

    modport slave (
        input  arw_valid, arw_payload_addr, arw_payload_id, arw_payload_len,
               arw_payload_size, arw_payload_burst, arw_payload_lock, arw_payload_write,
        output arw_ready,
        input  w_valid, w_payload_data, w_payload_strb, w_payload_last, w_payload_id,
        output w_ready,
        output b_valid, b_payload_id,
        input  b_ready,
        output r_valid, r_payload_data, r_payload_id, r_payload_resp, r_payload_last,
        input  r_ready
    );

endinterface

// File: rtl/tinyml_axi_order_fifo.sv
// -----------------------------------------------------------------------------
// tinyml_axi_order_fifo
// 1-bit wide queue remembering which requester owns each granted write, in
// grant order, so W beats are taken from the right requester.
//   clk, rst_n  : clock, async active-low reset (empties the queue)
//   push/push_data : enqueue a requester index
//   pop         : dequeue the head (ignored when empty)
//   head_data   : requester index at the head
//   full/empty  : occupancy flags
// -----------------------------------------------------------------------------
module tinyml_axi_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head_data,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/tinyml_axi_hd_arbiter.sv
// -----------------------------------------------------------------------------
// tinyml_axi_hd_arbiter
// Shares one half-duplex DDR AXI port between two requesters.
//   clk, rst_n : clock, async active-low reset
//   s0, s1     : requester bundles (slave side of the arbiter)
//   io_ddr     : DDR bundle, IDs one bit wider; the extra MSB is the requester
// ARW is round-robin arbitrated (IDLE -> GRANT -> IDLE); W follows grant order
// via the order queue; B/R are routed back by the ID MSB with no latency.
// -----------------------------------------------------------------------------
module tinyml_axi_hd_arbiter
    import tinyml_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int WQ_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tinyml_axi_hd_arbiter_if.slave  s0,
    tinyml_axi_hd_arbiter_if.slave  s1,
    tinyml_axi_hd_arbiter_if.master io_ddr
);
    localparam int PFX = id_prefix_pos(ID_WIDTH);

    arb_state_e state_q, state_d;
    logic       grant_idx_q, grant_idx_d;
    logic       last_idx_q, last_idx_d;

    logic wq_full, wq_empty, head_idx;
    logic elig0, elig1, granted, arw_fire, wq_push, wq_pop;

    // ---------------- ARW arbitration ----------------
    // A write is only eligible while the order queue has room for it.
    assign elig0    = s0.arw_valid & (~s0.arw_payload_write | ~wq_full);
    assign elig1    = s1.arw_valid & (~s1.arw_payload_write | ~wq_full);
    assign granted  = (state_q == GRANT);
    assign arw_fire = io_ddr.arw_valid & io_ddr.arw_ready;
    assign wq_push  = arw_fire & io_ddr.arw_payload_write;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    state_d     = GRANT;
                    grant_idx_d = (elig0 & elig1) ? ~last_idx_q : elig1;
                end
            end
            GRANT: begin
                if (arw_fire) begin
                    state_d    = IDLE;
                    last_idx_d = grant_idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_idx_q <= 1'b0;
            last_idx_q  <= 1'b1;  // requester 0 wins the first tie
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
        end
    end

    assign io_ddr.arw_valid         = granted & (grant_idx_q ? s1.arw_valid : s0.arw_valid);
    assign io_ddr.arw_payload_addr  = grant_idx_q ? s1.arw_payload_addr  : s0.arw_payload_addr;
    assign io_ddr.arw_payload_id    = {grant_idx_q, grant_idx_q ? s1.arw_payload_id : s0.arw_payload_id};
    assign io_ddr.arw_payload_len   = grant_idx_q ? s1.arw_payload_len   : s0.arw_payload_len;
    assign io_ddr.arw_payload_size  = grant_idx_q ? s1.arw_payload_size  : s0.arw_payload_size;
    assign io_ddr.arw_payload_burst = grant_idx_q ? s1.arw_payload_burst : s0.arw_payload_burst;
    assign io_ddr.arw_payload_lock  = grant_idx_q ? s1.arw_payload_lock  : s0.arw_payload_lock;
    assign io_ddr.arw_payload_write = grant_idx_q ? s1.arw_payload_write : s0.arw_payload_write;
    assign s0.arw_ready = granted & ~grant_idx_q & io_ddr.arw_ready;
    assign s1.arw_ready = granted &  grant_idx_q & io_ddr.arw_ready;

    // ---------------- W channel, in grant order ----------------
    tinyml_axi_order_fifo #(.DEPTH(WQ_DEPTH)) u_wq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wq_push),
        .push_data (grant_idx_q),
        .pop       (wq_pop),
        .head_data (head_idx),
        .full      (wq_full),
        .empty     (wq_empty)
    );

    assign io_ddr.w_valid        = ~wq_empty & (head_idx ? s1.w_valid : s0.w_valid);
    assign io_ddr.w_payload_data = head_idx ? s1.w_payload_data : s0.w_payload_data;
    assign io_ddr.w_payload_strb = head_idx ? s1.w_payload_strb : s0.w_payload_strb;
    assign io_ddr.w_payload_last = head_idx ? s1.w_payload_last : s0.w_payload_last;
    assign io_ddr.w_payload_id   = {head_idx, ID_WIDTH'(0)};
    assign s0.w_ready = ~wq_empty & ~head_idx & io_ddr.w_ready;
    assign s1.w_ready = ~wq_empty &  head_idx & io_ddr.w_ready;
    assign wq_pop     = io_ddr.w_valid & io_ddr.w_ready & io_ddr.w_payload_last;

    // ---------------- B/R return routing ----------------
    assign s0.b_valid      = io_ddr.b_valid & ~io_ddr.b_payload_id[PFX];
    assign s1.b_valid      = io_ddr.b_valid &  io_ddr.b_payload_id[PFX];
    assign s0.b_payload_id = io_ddr.b_payload_id[ID_WIDTH-1:0];
    assign s1.b_payload_id = io_ddr.b_payload_id[ID_WIDTH-1:0];
    assign io_ddr.b_ready  = io_ddr.b_payload_id[PFX] ? s1.b_ready : s0.b_ready;

    assign s0.r_valid        = io_ddr.r_valid & ~io_ddr.r_payload_id[PFX];
    assign s1.r_valid        = io_ddr.r_valid &  io_ddr.r_payload_id[PFX];
    assign s0.r_payload_id   = io_ddr.r_payload_id[ID_WIDTH-1:0];
    assign s1.r_payload_id   = io_ddr.r_payload_id[ID_WIDTH-1:0];
    assign s0.r_payload_data = io_ddr.r_payload_data;
    assign s1.r_payload_data = io_ddr.r_payload_data;
    assign s0.r_payload_resp = io_ddr.r_payload_resp;
    assign s1.r_payload_resp = io_ddr.r_payload_resp;
    assign s0.r_payload_last = io_ddr.r_payload_last;
    assign s1.r_payload_last = io_ddr.r_payload_last;
    assign io_ddr.r_ready    = io_ddr.r_payload_id[PFX] ? s1.r_ready : s0.r_ready;

endmodule

// File: tb/tb_tinyml_axi_hd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tinyml_axi_hd_arbiter
// Table of B/R routing vectors plus directed multi-cycle sequences for
// arbitration order, W forwarding, queue-full blocking, simultaneous
// push/pop and mid-grant reset.
// -----------------------------------------------------------------------------
module tb_tinyml_axi_hd_arbiter;
    import tinyml_axi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tinyml_axi_hd_arbiter_if #(.ID_WIDTH(8)) s0_if ();
    tinyml_axi_hd_arbiter_if #(.ID_WIDTH(8)) s1_if ();
    tinyml_axi_hd_arbiter_if #(.ID_WIDTH(9)) ddr_if ();

    tinyml_axi_hd_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .WQ_DEPTH(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s0     (s0_if),
        .s1     (s1_if),
        .io_ddr (ddr_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    typedef struct {
        logic        b_valid;
        logic [8:0]  b_id;
        logic        s0_b_ready, s1_b_ready;
        logic        r_valid;
        logic [8:0]  r_id;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_last;
        logic        s0_r_ready, s1_r_ready;
        logic        e_s0_bv, e_s1_bv;
        logic [7:0]  e_bid;
        logic        e_b_ready;
        logic        e_s0_rv, e_s1_rv;
        logic [7:0]  e_rid;
        logic        e_r_ready;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 9'h0AB, 1'b1, 1'b0, 1'b1, 9'h105, 32'hDEADBEEF, 2'd2, 1'b1, 1'b0, 1'b1,
                    1'b1, 1'b0, 8'hAB, 1'b1, 1'b0, 1'b1, 8'h05, 1'b1};
        vecs[1] = '{1'b1, 9'h1CD, 1'b1, 1'b0, 1'b1, 9'h105, 32'h12345678, 2'd0, 1'b0, 1'b1, 1'b0,
                    1'b0, 1'b1, 8'hCD, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0};
        vecs[2] = '{1'b1, 9'h1CD, 1'b0, 1'b1, 1'b1, 9'h0FF, 32'hCAFEF00D, 2'd1, 1'b1, 1'b1, 1'b0,
                    1'b0, 1'b1, 8'hCD, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[3] = '{1'b0, 9'h012, 1'b1, 1'b1, 1'b0, 9'h180, 32'h00000000, 2'd0, 1'b0, 1'b1, 1'b0,
                    1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0};
        vecs[4] = '{1'b1, 9'h000, 1'b0, 1'b1, 1'b1, 9'h1FF, 32'hA5A5A5A5, 2'd3, 1'b1, 1'b0, 1'b1,
                    1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1};

        // Requester and DDR-side inputs idle.
        s0_if.arw_valid = 0; s0_if.arw_payload_addr = 32'h1000; s0_if.arw_payload_id = 0;
        s0_if.arw_payload_len = 0; s0_if.arw_payload_size = 3'd2; s0_if.arw_payload_burst = 2'd1;
        s0_if.arw_payload_lock = 0; s0_if.arw_payload_write = 0;
        s0_if.w_valid = 0; s0_if.w_payload_data = 32'h5555_0000; s0_if.w_payload_strb = 4'hF;
        s0_if.w_payload_last = 0; s0_if.w_payload_id = 0; s0_if.b_ready = 0; s0_if.r_ready = 0;
        s1_if.arw_valid = 0; s1_if.arw_payload_addr = 32'h2000; s1_if.arw_payload_id = 0;
        s1_if.arw_payload_len = 0; s1_if.arw_payload_size = 3'd2; s1_if.arw_payload_burst = 2'd1;
        s1_if.arw_payload_lock = 0; s1_if.arw_payload_write = 0;
        s1_if.w_valid = 0; s1_if.w_payload_data = 0; s1_if.w_payload_strb = 4'hF;
        s1_if.w_payload_last = 0; s1_if.w_payload_id = 0; s1_if.b_ready = 0; s1_if.r_ready = 0;
        ddr_if.arw_ready = 0; ddr_if.w_ready = 0;
        ddr_if.b_valid = 0; ddr_if.b_payload_id = 0;
        ddr_if.r_valid = 0; ddr_if.r_payload_id = 0; ddr_if.r_payload_data = 0;
        ddr_if.r_payload_resp = 0; ddr_if.r_payload_last = 0;

        // ---- Reset state (requesters asking, so ready=0 is meaningful) ----
        s0_if.arw_valid = 1;
        s0_if.w_valid = 1;
        ddr_if.arw_ready = 1; ddr_if.w_ready = 1;
        repeat (2) tick();
        check("rst_arw_valid", 64'(ddr_if.arw_valid), 64'd0);
        check("rst_w_valid", 64'(ddr_if.w_valid), 64'd0);
        check("rst_s0_arw_ready", 64'(s0_if.arw_ready), 64'd0);
        check("rst_s0_w_ready", 64'(s0_if.w_ready), 64'd0);
        s0_if.arw_valid = 0; s0_if.w_valid = 0;
        tick();
        rst_n = 1;

        // ---- Table: combinational B/R routing ----
        for (int i = 0; i < 5; i++) begin
            ddr_if.b_valid = vecs[i].b_valid; ddr_if.b_payload_id = vecs[i].b_id;
            s0_if.b_ready = vecs[i].s0_b_ready; s1_if.b_ready = vecs[i].s1_b_ready;
            ddr_if.r_valid = vecs[i].r_valid; ddr_if.r_payload_id = vecs[i].r_id;
            ddr_if.r_payload_data = vecs[i].r_data; ddr_if.r_payload_resp = vecs[i].r_resp;
            ddr_if.r_payload_last = vecs[i].r_last;
            s0_if.r_ready = vecs[i].s0_r_ready; s1_if.r_ready = vecs[i].s1_r_ready;
            #1;
            check($sformatf("v%0d_s0_b_valid", i), 64'(s0_if.b_valid), 64'(vecs[i].e_s0_bv));
            check($sformatf("v%0d_s1_b_valid", i), 64'(s1_if.b_valid), 64'(vecs[i].e_s1_bv));
            check($sformatf("v%0d_b_id", i),
                  64'(vecs[i].b_id[8] ? s1_if.b_payload_id : s0_if.b_payload_id), 64'(vecs[i].e_bid));
            check($sformatf("v%0d_ddr_b_ready", i), 64'(ddr_if.b_ready), 64'(vecs[i].e_b_ready));
            check($sformatf("v%0d_s0_r_valid", i), 64'(s0_if.r_valid), 64'(vecs[i].e_s0_rv));
            check($sformatf("v%0d_s1_r_valid", i), 64'(s1_if.r_valid), 64'(vecs[i].e_s1_rv));
            check($sformatf("v%0d_r_id", i),
                  64'(vecs[i].r_id[8] ? s1_if.r_payload_id : s0_if.r_payload_id), 64'(vecs[i].e_rid));
            check($sformatf("v%0d_r_data", i),
                  64'(vecs[i].r_id[8] ? s1_if.r_payload_data : s0_if.r_payload_data), 64'(vecs[i].r_data));
            check($sformatf("v%0d_r_resp_last", i),
                  64'(vecs[i].r_id[8] ? {s1_if.r_payload_resp, s1_if.r_payload_last}
                                      : {s0_if.r_payload_resp, s0_if.r_payload_last}),
                  64'({vecs[i].r_resp, vecs[i].r_last}));
            check($sformatf("v%0d_ddr_r_ready", i), 64'(ddr_if.r_ready), 64'(vecs[i].e_r_ready));
        end
        ddr_if.b_valid = 0; ddr_if.r_valid = 0;
        ddr_if.w_ready = 0;
        tick();

        // ---- Simultaneous reads: s0 first (tie after reset), then s1 ----
        s0_if.arw_payload_id = 8'h11; s0_if.arw_valid = 1;
        s1_if.arw_payload_id = 8'h22; s1_if.arw_valid = 1;
        ddr_if.arw_ready = 1;
        half();
        check("rr_idle_no_valid", 64'(ddr_if.arw_valid), 64'd0);
        tick();
        half();
        check("rr_first_valid", 64'(ddr_if.arw_valid), 64'd1);
        check("rr_first_id", 64'(ddr_if.arw_payload_id), 64'h011);
        check("rr_first_addr", 64'(ddr_if.arw_payload_addr), 64'h1000);
        check("rr_first_readies", 64'({s0_if.arw_ready, s1_if.arw_ready}), 64'b10);
        tick();
        s0_if.arw_valid = 0;
        half();
        check("rr_gap_cycle", 64'(ddr_if.arw_valid), 64'd0);
        tick();
        half();
        check("rr_second_id", 64'(ddr_if.arw_payload_id), 64'h122);
        check("rr_second_addr", 64'(ddr_if.arw_payload_addr), 64'h2000);
        check("rr_second_readies", 64'({s0_if.arw_ready, s1_if.arw_ready}), 64'b01);
        tick();
        s1_if.arw_valid = 0;

        // ---- s1 write, len=3: four beats from s1 only ----
        s1_if.arw_payload_id = 8'h33; s1_if.arw_payload_write = 1;
        s1_if.arw_payload_len = 8'd3; s1_if.arw_valid = 1;
        tick();
        half();
        check("wr_arw_id", 64'(ddr_if.arw_payload_id), 64'h133);
        check("wr_arw_len_write", 64'({ddr_if.arw_payload_len, ddr_if.arw_payload_write}), 64'({8'd3, 1'b1}));
        tick();
        s1_if.arw_valid = 0;
        ddr_if.w_ready = 1;
        s0_if.w_valid = 1;
        for (int b = 0; b < 4; b++) begin
            s1_if.w_valid = 1;
            s1_if.w_payload_data = 32'hA0 + 32'(b);
            s1_if.w_payload_last = (b == 3);
            half();
            check($sformatf("wr_beat%0d_valid_data", b),
                  64'({ddr_if.w_valid, ddr_if.w_payload_data}), 64'({1'b1, 32'hA0 + 32'(b)}));
            check($sformatf("wr_beat%0d_readies", b), 64'({s0_if.w_ready, s1_if.w_ready}), 64'b01);
            check($sformatf("wr_beat%0d_id_last", b),
                  64'({ddr_if.w_payload_id, ddr_if.w_payload_last}), 64'({9'h100, b == 3}));
            tick();
        end
        s1_if.w_valid = 0; s0_if.w_valid = 0; s1_if.w_payload_last = 0;
        half();
        check("wr_queue_empty", 64'(dut.u_wq.count_q), 64'd0);
        check("wr_after_readies", 64'({ddr_if.w_valid, s0_if.w_ready, s1_if.w_ready}), 64'b000);

        // ---- Fill queue with s0 writes; s1 write blocked, s1 read granted ----
        tick();
        ddr_if.w_ready = 0;
        s0_if.arw_payload_write = 1; s0_if.arw_payload_id = 8'h50; s0_if.arw_valid = 1;
        repeat (8) tick();
        s0_if.arw_valid = 0;
        s1_if.arw_payload_id = 8'h55; s1_if.arw_payload_write = 1; s1_if.arw_valid = 1;
        half();
        check("full_count", 64'(dut.u_wq.count_q), 64'd4);
        tick(); tick();
        half();
        check("full_write_blocked", 64'({ddr_if.arw_valid, s1_if.arw_ready}), 64'b00);
        s1_if.arw_payload_write = 0; s1_if.arw_payload_id = 8'h44;
        tick();
        half();
        check("full_read_granted", 64'({ddr_if.arw_valid, ddr_if.arw_payload_write}), 64'b10);
        check("full_read_id", 64'(ddr_if.arw_payload_id), 64'h144);
        tick();
        s1_if.arw_valid = 0;
        half();
        check("full_read_no_push", 64'(dut.u_wq.count_q), 64'd4);

        // Drain the four single-beat s0 writes.
        tick();
        ddr_if.w_ready = 1; s0_if.w_valid = 1; s0_if.w_payload_last = 1;
        repeat (4) tick();
        s0_if.w_valid = 0; ddr_if.w_ready = 0;
        half();
        check("drain_empty", 64'(dut.u_wq.count_q), 64'd0);

        // ---- Queue [s0, s1], then push s0 while popping head ----
        tick();
        s0_if.arw_valid = 1; tick(); tick(); s0_if.arw_valid = 0;
        s1_if.arw_payload_write = 1; s1_if.arw_valid = 1; tick(); tick(); s1_if.arw_valid = 0;
        half();
        check("pp_count_before", 64'(dut.u_wq.count_q), 64'd2);
        tick();
        s0_if.arw_valid = 1;
        tick();
        s0_if.w_valid = 1; s0_if.w_payload_last = 1; ddr_if.w_ready = 1;
        half();
        check("pp_grant_and_head", 64'({ddr_if.arw_valid, ddr_if.w_valid, ddr_if.w_payload_id}),
              64'({1'b1, 1'b1, 9'h000}));
        tick();
        s0_if.arw_valid = 0; s0_if.w_valid = 0; ddr_if.w_ready = 0;
        s1_if.w_valid = 1; s1_if.w_payload_last = 1;
        half();
        check("pp_count_after", 64'(dut.u_wq.count_q), 64'd2);
        check("pp_head_advanced", 64'({ddr_if.w_valid, ddr_if.w_payload_id}), 64'({1'b1, 9'h100}));
        tick();
        ddr_if.w_ready = 1;
        tick();
        s1_if.w_valid = 0; ddr_if.w_ready = 0;
        half();
        check("pp_tail_is_s0", 64'({dut.u_wq.count_q, ddr_if.w_payload_id}), 64'({3'd1, 9'h000}));

        // ---- Reset while a grant is pending ----
        tick();
        ddr_if.arw_ready = 0; ddr_if.w_ready = 1;
        s0_if.arw_payload_write = 0; s0_if.arw_payload_id = 8'h77; s0_if.arw_valid = 1;
        tick();
        half();
        check("mid_grant_valid", 64'({ddr_if.arw_valid, s0_if.w_ready}), 64'b11);
        #1 rst_n = 0;
        #1;
        check("mid_rst_arw_valid", 64'(ddr_if.arw_valid), 64'd0);
        check("mid_rst_queue", 64'(dut.u_wq.count_q), 64'd0);
        check("mid_rst_readies", 64'({s0_if.arw_ready, s0_if.w_ready, s1_if.w_ready}), 64'b000);
        tick(); tick();
        rst_n = 1;
        half();
        check("mid_rst_state_idle", 64'(dut.state_q), 64'(IDLE));
        check("mid_rst_no_valid", 64'(ddr_if.arw_valid), 64'd0);
        s0_if.arw_valid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
